// File: rtl/pipe_rr_sched.sv
// Two-requester round-robin front end for a DEPTH-stage register pipeline.
// Each stage carries valid, data and source id. Backpressure stalls every stage together.
module pipe_rr_sched #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  input  logic          out_ready,
  output logic          busy
);

  typedef struct packed {
    logic          vld;
    logic          src;
    logic [DW-1:0] dat;
  } stage_t;

  stage_t        stg [DEPTH];
  logic          last;
  logic          adv;
  logic          grant_vld;
  logic          grant_id;
  logic [DW-1:0] grant_dat;
  logic          accept;

  // A full last stage that downstream refuses freezes the whole chain.
  assign adv = !stg[DEPTH-1].vld || out_ready;

  // Round-robin grant: a lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant_vld = req0_valid || req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = !last;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    grant_dat = grant_id ? req1_data : req0_data;
  end

  assign accept     = adv && grant_vld && !flush && !rst;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i] <= '0;
      end
      last <= 1'b1;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i].vld <= 1'b0;
      end
    end else if (adv) begin
      for (int i = 1; i < DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
      stg[0].vld <= grant_vld;
      // On a bubble the stage-0 payload keeps its old, defined value.
      if (grant_vld) begin
        stg[0].dat <= grant_dat;
        stg[0].src <= grant_id;
        last       <= grant_id;
      end
    end
  end

  assign out_valid = stg[DEPTH-1].vld;
  assign out_data  = stg[DEPTH-1].dat;
  assign out_src   = stg[DEPTH-1].src;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | stg[i].vld;
    end
  end

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Randomized scoreboard bench for pipe_rr_sched with a slot-occupancy reference model.
module tb_pipe_rr_sched;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          req0_valid = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready = 1'b0;
  logic          busy;

  pipe_rr_sched #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  bit   occ[$];
  bit   m_last = 1'b1;
  bit   pending_clear = 1'b0;
  bit   last_acc;
  bit   last_gid;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // One clock of stimulus: drive inputs, check handshake/occupancy, then advance the model.
  task automatic cycle(input bit r, input bit f, input bit v0, input logic [DW-1:0] d0,
                       input bit v1, input logic [DW-1:0] d1, input bit ordy);
    bit madv, gv, gid, e0, e1, any;
    @(negedge clk);
    if (pending_clear) begin
      sb.delete();
      pending_clear = 1'b0;
    end
    rst = r; flush = f;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    out_ready = ordy;
    #1;
    madv = !occ[DEPTH-1] || ordy;
    gv   = v0 || v1;
    gid  = (v0 && v1) ? !m_last : v1;
    e0   = madv && gv && !f && !r && !gid;
    e1   = madv && gv && !f && !r && gid;
    any  = 1'b0;
    foreach (occ[i]) any |= occ[i];
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("out_valid", 32'(out_valid), 32'(occ[DEPTH-1]));
    chk("busy", 32'(busy), 32'(any));
    last_acc = e0 || e1;
    last_gid = gid;
    if (last_acc) sb.push_back('{src: gid, data: gid ? d1 : d0});
    if (r) begin
      foreach (occ[i]) occ[i] = 1'b0;
      m_last = 1'b1;
      pending_clear = 1'b1;
    end else if (f) begin
      foreach (occ[i]) occ[i] = 1'b0;
      pending_clear = 1'b1;
    end else if (madv) begin
      void'(occ.pop_back());
      occ.push_front(last_acc);
      if (last_acc) m_last = gid;
    end
  endtask

  // Monitor: compare whatever the DUT presents against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL out_unexpected: got data %0h src %0b expected no word at %0t",
                   out_data, out_src, $time);
        end else begin
          e = sb[0];
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_src", 32'(out_src), 32'(e.src));
          if (out_ready && !rst) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int ia, ib, n;
    for (int i = 0; i < DEPTH; i++) occ.push_back(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single word latency: accepted at edge 1, visible after edge 3, gone after edge 4.
    cycle(0, 0, 1, 8'h11, 0, 8'h00, 1);
    chk("lat_ready0", 32'(req0_ready), 32'd1);
    cycle(0, 0, 0, 8'h00, 0, 8'h00, 1);
    chk("lat_busy_e1", 32'(busy), 32'd1);
    cycle(0, 0, 0, 8'h00, 0, 8'h00, 1);
    chk("lat_valid_e2", 32'(out_valid), 32'd0);
    cycle(0, 0, 0, 8'h00, 0, 8'h00, 1);
    chk("lat_valid_e3", 32'(out_valid), 32'd1);
    chk("lat_data_e3", 32'(out_data), 32'h11);
    chk("lat_src_e3", 32'(out_src), 32'd0);
    cycle(0, 0, 0, 8'h00, 0, 8'h00, 1);
    chk("lat_busy_e4", 32'(busy), 32'd0);

    // Reset, then both requesters saturated: first tie to req0, then strict alternation.
    cycle(1, 0, 0, 8'h00, 0, 8'h00, 1);
    ia = 0; ib = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 1, 8'(8'hA0 + ia), 1, 8'(8'hB0 + ib), 1);
      if (k == 0) chk("tie_req0_first", 32'(req0_ready), 32'd1);
      if (last_acc) begin
        if (last_gid) ib++;
        else ia++;
      end
    end
    chk("alt_count_a", 32'(ia), 32'd4);
    chk("alt_count_b", 32'(ib), 32'd4);

    // Stall with a full pipeline for 4 cycles, then release.
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1, 8'(8'hA0 + ia), 1, 8'(8'hB0 + ib), 0);
      chk("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1, 8'(8'hA0 + ia), 1, 8'(8'hB0 + ib), 1);
      if (last_acc) begin
        if (last_gid) ib++;
        else ia++;
      end
    end

    // Lone requester is granted every cycle regardless of pointer.
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0, 8'h00, 1, 8'(8'hC0 + k), 1);
      chk("single_ready1", 32'(req1_ready), 32'd1);
    end

    // Flush a full, stalled pipeline; the word offered in the flush cycle is refused.
    cycle(0, 0, 1, 8'h51, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h52, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h53, 0, 8'h00, 0);
    cycle(0, 1, 1, 8'h54, 0, 8'h00, 0);
    chk("flush_ready0", 32'(req0_ready), 32'd0);
    cycle(0, 0, 0, 8'h00, 0, 8'h00, 0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);

    // Reset mid-stream.
    for (int k = 0; k < 5; k++)
      cycle(0, 0, 1, 8'($urandom_range(0, 255)), 1, 8'($urandom_range(0, 255)), k[0]);
    cycle(1, 0, 1, 8'h77, 1, 8'h88, 1);
    cycle(0, 0, 1, 8'h61, 1, 8'h62, 1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data", 32'(out_data), 32'd0);
    chk("mrst_out_src", 32'(out_src), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_tie_req0", 32'(req0_ready), 32'd1);

    // Randomized traffic with occasional flush and reset.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 70));
    end

    // Drain within a bounded number of cycles.
    n = 0;
    while ((sb.size() != 0 || pending_clear) && n < 20) begin
      cycle(0, 0, 0, 8'h00, 0, 8'h00, 1);
      n++;
    end
    cycle(0, 0, 0, 8'h00, 0, 8'h00, 1);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
